fft_sample_loader: RTL and testbench

Acquisition front end of the 32-point FFT path. Paces conversions by pulsing `sample` to the SPI ADC reader at a fixed rate and captures each completed conversion on the rising edge of its data-valid. It stores one frame of N samples in an internal buffer, in bit-reversed order for the decimation-in-time butterflies. It then holds the frame for the FFT stage to read until that stage acknowledges it.

---
 rtl/fft_sample_loader.sv | 159 +++++++++++++++
 tb/tb_fft_sample_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_loader.sv
// rtl/fft_sample_loader.sv - ADC sample pacing and bit-reversed frame buffer for the FFT path
//
// Paces ADC conversions with a free-running period counter, captures each
// conversion on the rising edge of its data-valid, and fills an N_POINTS
// frame buffer. A full frame is held until the FFT stage acknowledges it.
//
// Optional feature macro: FFT_LOADER_BITREV_EN
//   defined   : write address is idx with its address bits reversed
//   undefined : write address is idx (natural order)
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   adc_data     ADC reader sample
//   adc_dv       ADC reader data valid (may be held for several cycles)
//   sample       start-conversion pulse to the ADC reader
//   frame_ready  buffer holds a complete frame
//   frame_ack    FFT stage has consumed the frame
//   rd_addr      buffer read address
//   rd_data      buffer read data, one cycle after rd_addr
//   overrun      sticky: a tick arrived while a conversion was pending

module fft_sample_loader #(
    parameter int N_POINTS      = 32,
    parameter int DATA_WIDTH    = 8,
    parameter int SAMPLE_PERIOD = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       adc_data,
    input  logic                        adc_dv,
    output logic                        sample,
    output logic                        frame_ready,
    input  logic                        frame_ack,
    input  logic [$clog2(N_POINTS)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        overrun
);

    localparam int AW = $clog2(N_POINTS);
    localparam int TW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [1:0] {
        WAIT_TICK = 2'd0,
        WAIT_DV   = 2'd1,
        FULL      = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [TW-1:0]         tcnt;
    logic [AW-1:0]         idx, idx_next;
    logic [AW-1:0]         wr_addr;
    logic                  dv_q;
    logic                  dv_rise;
    logic                  tick;
    logic                  wr_en;
    logic                  sample_next;
    logic                  ready_next;
    logic                  overrun_next;
    logic [DATA_WIDTH-1:0] mem [N_POINTS];

    assign tick    = (tcnt == TW'(SAMPLE_PERIOD - 1));
    assign dv_rise = adc_dv & ~dv_q;

    always_comb begin
        wr_addr = idx;
`ifdef FFT_LOADER_BITREV_EN
        for (int i = 0; i < AW; i++) begin
            wr_addr[i] = idx[AW-1-i];
        end
`endif
    end

    // Period counter free-runs in every state so the tick grid is fixed
    // relative to reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            dv_q <= 1'b0;
        end else begin
            tcnt <= tick ? '0 : tcnt + TW'(1);
            dv_q <= adc_dv;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_TICK;
            idx         <= '0;
            sample      <= 1'b0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            sample      <= sample_next;
            frame_ready <= ready_next;
            overrun     <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        sample_next  = 1'b0;
        ready_next   = frame_ready;
        overrun_next = overrun;
        wr_en        = 1'b0;
        case (state)
            WAIT_TICK: begin
                if (tick) begin
                    sample_next = 1'b1;
                    state_next  = WAIT_DV;
                end
            end
            WAIT_DV: begin
                // A capture coinciding with a tick takes priority; that tick
                // is then simply not used to start a conversion.
                if (dv_rise) begin
                    wr_en = 1'b1;
                    if (idx == AW'(N_POINTS - 1)) begin
                        idx_next   = '0;
                        ready_next = 1'b1;
                        state_next = FULL;
                    end else begin
                        idx_next   = idx + AW'(1);
                        state_next = WAIT_TICK;
                    end
                end else if (tick) begin
                    overrun_next = 1'b1;
                end
            end
            FULL: begin
                if (frame_ack && frame_ready) begin
                    ready_next = 1'b0;
                    state_next = WAIT_TICK;
                end
            end
            default: state_next = WAIT_TICK;
        endcase
    end

    // Buffer is deliberately not reset; a same-cycle read of the written
    // address returns the previous contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= adc_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// tb/tb_fft_sample_loader.sv - self-checking bench for fft_sample_loader

module tb_fft_sample_loader;

    localparam int N  = 32;
    localparam int SP = 64;

    logic       clk;
    logic       rst;
    logic [7:0] adc_data;
    logic       adc_dv;
    logic       sample;
    logic       frame_ready;
    logic       frame_ack;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic       overrun;

    logic       m_dv;
    logic [7:0] m_data;
    logic       inj_dv;
    logic [7:0] inj_data;

    assign adc_dv   = m_dv | inj_dv;
    assign adc_data = inj_dv ? inj_data : m_data;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_samples = 0;
    int         sample_cyc = 0;
    bit         adc_busy = 1'b0;
    bit         use_rand = 1'b0;
    int         adc_delay = 40;
    int         adc_hold = 1;
    time        last_dv_time = 0;
    logic [7:0] conv_vals[$];
    logic [7:0] adc_v;
    int         adc_d;

    fft_sample_loader #(
        .N_POINTS     (N),
        .DATA_WIDTH   (8),
        .SAMPLE_PERIOD(SP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_data   (adc_data),
        .adc_dv     (adc_dv),
        .sample     (sample),
        .frame_ready(frame_ready),
        .frame_ack  (frame_ack),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle count since reset release: sample is due after edges that are
    // multiples of SP.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // ADC reader model: answers each sample pulse with one conversion.
    initial begin
        m_dv   = 1'b0;
        m_data = 8'h00;
        forever begin
            @(negedge clk);
            if (sample === 1'b1) begin
                adc_busy   = 1'b1;
                n_samples  = n_samples + 1;
                sample_cyc = cyc;
                adc_v = use_rand ? 8'($urandom) : 8'(conv_vals.size() + 16);
                adc_d = use_rand ? int'($urandom_range(60, 5)) : adc_delay;
                repeat (adc_d) @(posedge clk);
                #1;
                m_dv   = 1'b1;
                m_data = adc_v;
                conv_vals.push_back(adc_v);
                last_dv_time = $time;
                repeat (adc_hold) @(posedge clk);
                #1;
                m_dv     = 1'b0;
                adc_busy = 1'b0;
            end
        end
    end

    function automatic int map_addr(input int k);
`ifdef FFT_LOADER_BITREV_EN
        int r = 0;
        for (int b = 0; b < 5; b++) r = r * 2 + ((k >> b) & 1);
        return r;
`else
        return k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        rd_addr = 5'(a);
        @(posedge clk);
        #1;
        d = rd_data;
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [7:0] expm[N];
        logic [7:0] d;
        int cnt;
        cnt = conv_vals.size() - base;
        chk({tag, "_convs"}, cnt, N);
        for (int a = 0; a < N; a++) expm[a] = 8'h00;
        for (int k = 0; k < N; k++)
            if (base + k < conv_vals.size()) expm[map_addr(k)] = conv_vals[base + k];
        for (int a = 0; a < N; a++) begin
            rd(a, d);
            chk($sformatf("%s_addr%0d", tag, a), d, expm[a]);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && frame_ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_ready"}, frame_ready, 1'b1);
        chk({tag, "_ready_latency"}, 32'($time - last_dv_time), 10);
    endtask

    task automatic ack_frame(output int a);
        a = cyc;
        frame_ack = 1'b1;
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        chk("ack_clears_ready", frame_ready, 1'b0);
    endtask

    initial begin
        int         first;
        int         bad;
        int         sbase;
        int         cbase;
        int         a;
        logic [7:0] d;

        rst      = 1'b1;
        frame_ack = 1'b0;
        rd_addr  = 5'd0;
        inj_dv   = 1'b0;
        inj_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", sample, 1'b0);
        chk("rst_ready", frame_ready, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);

        // Reset release: first sample pulse at cycle 64
        sbase = n_samples;
        cbase = conv_vals.size();
        rst   = 1'b0;
        first = -1;
        bad   = 0;
        for (int c = 1; c <= 100 && first < 0; c++) begin
            @(posedge clk);
            #1;
            if (sample === 1'b1) first = c;
            else if (frame_ready !== 1'b0 || overrun !== 1'b0) bad++;
        end
        chk("first_sample_cycle", first, 64);
        chk("outputs_zero_before_tick", bad, 0);

        // Frame 1: ADC returns k+8'h10, DV 40 cycles after sample
        wait_ready("f1", N * SP + 300);
        chk("f1_samples", n_samples - sbase, N);
        chk("f1_overrun", overrun, 1'b0);
        check_frame("f1", cbase);
`ifdef FFT_LOADER_BITREV_EN
        rd(0, d);  chk("plan_a0", d, 8'h10);
        rd(16, d); chk("plan_a16", d, 8'h11);
        rd(8, d);  chk("plan_a8", d, 8'h12);
        rd(31, d); chk("plan_a31", d, 8'h2F);
`else
        rd(0, d);  chk("plan_a0", d, 8'h10);
        rd(1, d);  chk("plan_a1", d, 8'h11);
        rd(31, d); chk("plan_a31", d, 8'h2F);
`endif

        // FULL hold: no samples, stray DV ignored, buffer unchanged
        sbase = n_samples;
        repeat (100) @(posedge clk);
        #1;
        inj_data = 8'hEE;
        inj_dv   = 1'b1;
        @(posedge clk);
        #1;
        inj_dv = 1'b0;
        repeat (400) @(posedge clk);
        #1;
        chk("hold_samples", n_samples - sbase, 0);
        chk("hold_overrun", overrun, 1'b0);
        chk("hold_ready", frame_ready, 1'b1);
        check_frame("hold", cbase);

        // Frame 2: random data and conversion times; restart on next tick
        use_rand = 1'b1;
        sbase    = n_samples;
        cbase    = conv_vals.size();
        ack_frame(a);
        for (int i = 0; i < 200 && n_samples - sbase < 1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("restart_sample_cycle", sample_cyc, ((a + 1) / SP + 1) * SP);
        repeat (300) @(posedge clk);
        #1;
        frame_ack = 1'b1;            // ack outside FULL must do nothing
        @(posedge clk);
        #1;
        frame_ack = 1'b0;
        wait_ready("f2", N * SP + 300);
        chk("f2_samples", n_samples - sbase, N);
        chk("f2_overrun", overrun, 1'b0);
        check_frame("f2", cbase);

        // Frame 3: slow ADC (DV 100 cycles late, held 3 cycles)
        use_rand  = 1'b0;
        adc_delay = 100;
        adc_hold  = 3;
        sbase     = n_samples;
        cbase     = conv_vals.size();
        ack_frame(a);
        for (int i = 0; i < 200 && n_samples - sbase < 1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("slow_overrun_before", overrun, 1'b0);
        for (int i = 0; i < 300 && (conv_vals.size() - cbase < 1 || adc_busy); i++) begin
            @(posedge clk);
            #1;
        end
        chk("slow_overrun_after", overrun, 1'b1);
        wait_ready("f3", N * 2 * SP + 400);
        chk("f3_samples", n_samples - sbase, N);
        check_frame("f3", cbase);

        // Frame 4: reset after 10 samples, mid-conversion
        adc_delay = 40;
        adc_hold  = 1;
        sbase     = n_samples;
        cbase     = conv_vals.size();
        ack_frame(a);
        for (int i = 0; i < 2000 && (conv_vals.size() - cbase < 10 || n_samples - sbase < 11); i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_progress", n_samples - sbase, 11);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_sample", sample, 1'b0);
        chk("midrst_ready", frame_ready, 1'b0);
        chk("midrst_overrun", overrun, 1'b0);
        chk("midrst_rd_data", rd_data, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 100 && adc_busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_adc_idle", adc_busy, 1'b0);
        sbase = n_samples;
        cbase = conv_vals.size();
        wait_ready("f4", N * SP + 300);
        chk("f4_samples", n_samples - sbase, N);
        chk("f4_overrun", overrun, 1'b0);
        check_frame("f4", cbase);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
